// File: rtl/addsub_seq_flags.sv
// Multi-cycle add/subtract unit with NZCV flags; processes LIMB bits per cycle
// through a registered carry chain behind valid/ready handshakes.
module addsub_seq_flags #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LIMB  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  input  logic             rev,
  input  logic             use_cin,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             n_flag,
  output logic             z_flag,
  output logic             c_flag,
  output logic             v_flag
);

  localparam int unsigned NLIMB = WIDTH / LIMB;
  localparam int unsigned KW    = (NLIMB > 1) ? $clog2(NLIMB) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_in_ready;
  logic             w_in_ready_nxt;
  logic             r_out_valid;
  logic             w_out_valid_nxt;

  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_s;
  logic             r_cy;
  logic [KW-1:0]    r_k;
  logic             r_z;
  logic             r_c;
  logic             r_v;

  logic             w_accept;
  logic             w_calc;
  logic             w_last;
  logic [WIDTH-1:0] w_x_sel;
  logic [WIDTH-1:0] w_y_sel;
  logic [LIMB:0]    w_sum;
  logic             w_cy_msb;
  logic [WIDTH-1:0] w_s_nxt;

  assign w_accept = in_valid && r_in_ready;
  assign w_calc   = (r_state == S_CALC);
  assign w_last   = w_calc && (r_k == KW'(NLIMB - 1));
  assign w_x_sel  = rev ? b : a;
  assign w_y_sel  = rev ? a : b;

  // One limb of the ripple: the low limb of the shifting operand registers.
  assign w_sum    = {1'b0, r_x[LIMB-1:0]} + {1'b0, r_y[LIMB-1:0]} + {{LIMB{1'b0}}, r_cy};
  assign w_cy_msb = r_x[LIMB-1] ^ r_y[LIMB-1] ^ w_sum[LIMB-1];

  // Result limbs shift in from the top so limb 0 lands at the bottom after NLIMB steps.
  if (NLIMB == 1) begin : g_one_limb
    assign w_s_nxt = w_sum[LIMB-1:0];
  end else begin : g_multi_limb
    assign w_s_nxt = {w_sum[LIMB-1:0], r_s[WIDTH-1:LIMB]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_in_ready_nxt  = r_in_ready;
    w_out_valid_nxt = r_out_valid;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt    = S_CALC;
          w_in_ready_nxt = 1'b0;
        end
      end
      S_CALC: begin
        if (w_last) begin
          w_state_nxt     = S_DONE;
          w_out_valid_nxt = 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt     = S_IDLE;
          w_out_valid_nxt = 1'b0;
          w_in_ready_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_in_ready_nxt  = 1'b1;
        w_out_valid_nxt = 1'b0;
      end
    endcase
  end

  // Datapath: latch operands on accept, then consume one limb per CALC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x  <= '0;
      r_y  <= '0;
      r_s  <= '0;
      r_cy <= 1'b0;
      r_k  <= '0;
      r_z  <= 1'b0;
      r_c  <= 1'b0;
      r_v  <= 1'b0;
    end else if (w_accept) begin
      r_x  <= w_x_sel;
      r_y  <= op ? ~w_y_sel : w_y_sel;
      r_cy <= use_cin ? c_in : op;
      r_k  <= '0;
      r_z  <= 1'b1;
    end else if (w_calc) begin
      r_x  <= r_x >> LIMB;
      r_y  <= r_y >> LIMB;
      r_cy <= w_sum[LIMB];
      r_k  <= r_k + KW'(1);
      r_s  <= w_s_nxt;
      r_z  <= r_z & (w_sum[LIMB-1:0] == '0);
      if (w_last) begin
        r_c <= w_sum[LIMB];
        r_v <= w_sum[LIMB] ^ w_cy_msb;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign s         = r_s;
  assign n_flag    = r_s[WIDTH-1];
  assign z_flag    = r_z;
  assign c_flag    = r_c;
  assign v_flag    = r_v;

endmodule

// File: tb/tb_addsub_seq_flags.sv
// Randomised and directed checks of addsub_seq_flags in three geometries
// (32/8, 64/16, 32/32) against a plain-arithmetic reference model.
module tb_addsub_seq_flags;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [63:0] a_in;
  logic [63:0] b_in;
  logic        op;
  logic        rev;
  logic        use_cin;
  logic        c_in;

  logic        in_ready_a, out_valid_a, n_a, z_a, c_a, v_a;
  logic [31:0] s_a;
  logic        in_ready_b, out_valid_b, n_b, z_b, c_b, v_b;
  logic [63:0] s_b;
  logic        in_ready_c, out_valid_c, n_c, z_c, c_c, v_c;
  logic [31:0] s_c;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [63:0] s;
    logic [3:0]  f;
  } res_t;

  always #5 clk = ~clk;

  addsub_seq_flags #(.WIDTH(32), .LIMB(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .a(a_in[31:0]), .b(b_in[31:0]), .op(op), .rev(rev), .use_cin(use_cin), .c_in(c_in),
    .out_valid(out_valid_a), .out_ready(out_ready), .s(s_a),
    .n_flag(n_a), .z_flag(z_a), .c_flag(c_a), .v_flag(v_a)
  );

  addsub_seq_flags #(.WIDTH(64), .LIMB(16)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .a(a_in), .b(b_in), .op(op), .rev(rev), .use_cin(use_cin), .c_in(c_in),
    .out_valid(out_valid_b), .out_ready(out_ready), .s(s_b),
    .n_flag(n_b), .z_flag(z_b), .c_flag(c_b), .v_flag(v_b)
  );

  addsub_seq_flags #(.WIDTH(32), .LIMB(32)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_c),
    .a(a_in[31:0]), .b(b_in[31:0]), .op(op), .rev(rev), .use_cin(use_cin), .c_in(c_in),
    .out_valid(out_valid_c), .out_ready(out_ready), .s(s_c),
    .n_flag(n_c), .z_flag(z_c), .c_flag(c_c), .v_flag(v_c)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Whole-word reference: signed overflow from operand/result signs, not carry xor.
  function automatic res_t model(input logic [63:0] a_i, input logic [63:0] b_i,
                                 input logic op_i, input logic rev_i,
                                 input logic uc_i, input logic ci_i, input int w);
    logic [64:0] m, x, y, sum;
    res_t r;
    m   = (65'(1) << w) - 65'(1);
    x   = {1'b0, (rev_i ? b_i : a_i)} & m;
    y   = {1'b0, (rev_i ? a_i : b_i)} & m;
    if (op_i) y = ~y & m;
    sum = x + y + 65'(uc_i ? ci_i : op_i);
    r.s    = 64'(sum & m);
    r.f[3] = sum[w-1];
    r.f[2] = ((sum & m) == 65'(0));
    r.f[1] = sum[w];
    r.f[0] = (x[w-1] == y[w-1]) && (sum[w-1] != x[w-1]);
    return r;
  endfunction

  task automatic scramble();
    a_in    = {$urandom, $urandom};
    b_in    = {$urandom, $urandom};
    op      = 1'($urandom);
    rev     = 1'($urandom);
    use_cin = 1'($urandom);
    c_in    = 1'($urandom);
  endtask

  task automatic run_op(input string tag, input logic [63:0] a_i, input logic [63:0] b_i,
                        input logic op_i, input logic rev_i, input logic uc_i, input logic ci_i,
                        input int hold, input logic fixed,
                        input logic [31:0] s_exp, input logic [3:0] f_exp);
    res_t ra, rb;
    int   la, lb, lc;
    ra = model(a_i, b_i, op_i, rev_i, uc_i, ci_i, 32);
    rb = model(a_i, b_i, op_i, rev_i, uc_i, ci_i, 64);
    check({tag, " in_ready before accept"}, 64'(in_ready_a), 64'(1));
    a_in = a_i; b_in = b_i; op = op_i; rev = rev_i; use_cin = uc_i; c_in = ci_i;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble();
    la = 0; lb = 0; lc = 0;
    for (int cy = 1; cy <= 20; cy++) begin
      @(posedge clk); #1;
      if (out_valid_a && la == 0) la = cy;
      if (out_valid_b && lb == 0) lb = cy;
      if (out_valid_c && lc == 0) lc = cy;
      if (la != 0 && lb != 0 && lc != 0) break;
    end
    check({tag, " latency 32/8"},  64'(la), 64'(4));
    check({tag, " latency 64/16"}, 64'(lb), 64'(4));
    check({tag, " latency 32/32"}, 64'(lc), 64'(1));
    check({tag, " s 32/8"},     64'(s_a), ra.s);
    check({tag, " nzcv 32/8"},  64'({n_a, z_a, c_a, v_a}), 64'(ra.f));
    check({tag, " s 64/16"},    s_b, rb.s);
    check({tag, " nzcv 64/16"}, 64'({n_b, z_b, c_b, v_b}), 64'(rb.f));
    check({tag, " s 32/32"},    64'(s_c), ra.s);
    check({tag, " nzcv 32/32"}, 64'({n_c, z_c, c_c, v_c}), 64'(ra.f));
    if (fixed) begin
      check({tag, " s const"},    64'(s_a), 64'(s_exp));
      check({tag, " nzcv const"}, 64'({n_a, z_a, c_a, v_a}), 64'(f_exp));
    end
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      scramble();
      @(posedge clk); #1;
      check({tag, " hold s"},         64'(s_a), ra.s);
      check({tag, " hold nzcv"},      64'({n_a, z_a, c_a, v_a}), 64'(ra.f));
      check({tag, " hold in_ready"},  64'(in_ready_a), 64'(0));
      check({tag, " hold out_valid"}, 64'(out_valid_a), 64'(1));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " out_valid after pop"}, 64'(out_valid_a), 64'(0));
    check({tag, " in_ready after pop"},  64'(in_ready_a), 64'(1));
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a_in = '0; b_in = '0; op = 1'b0; rev = 1'b0; use_cin = 1'b0; c_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready",  64'(in_ready_a), 64'(1));
    check("reset out_valid", 64'(out_valid_a), 64'(0));
    check("reset s",         64'(s_a), 64'(0));
    check("reset nzcv",      64'({n_a, z_a, c_a, v_a}), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("t1 add",     64'h04E88C94, 64'h0000250B, 0, 0, 0, 0, 0, 1, 32'h04E8B19F, 4'b0000);
    run_op("t2 sub",     64'h04E88C94, 64'h0000250B, 1, 0, 0, 0, 0, 1, 32'h04E86789, 4'b0010);
    run_op("t2 rsb",     64'h04E88C94, 64'h0000250B, 1, 1, 0, 0, 0, 1, 32'hFB179877, 4'b1000);
    run_op("t3 adc",     64'h7FFFFFFF, 64'h00000000, 0, 0, 1, 1, 0, 1, 32'h80000000, 4'b1001);
    run_op("t3 sbc",     64'h12345678, 64'h12345678, 1, 0, 1, 0, 0, 1, 32'hFFFFFFFF, 4'b1000);
    run_op("t4 sub0",    64'hDEADBEEF, 64'hDEADBEEF, 1, 0, 0, 0, 0, 1, 32'h00000000, 4'b0110);
    run_op("t4 ripple",  64'hFFFFFFFF, 64'h00000001, 0, 0, 0, 0, 0, 1, 32'h00000000, 4'b0110);
    run_op("t5 backpr",  64'h80000000, 64'h80000000, 0, 0, 0, 0, 5, 1, 32'h00000000, 4'b0111);
    run_op("t5 b2b",     64'h00000005, 64'h00000007, 1, 0, 0, 0, 0, 1, 32'hFFFFFFFE, 4'b1000);

    for (int i = 0; i < 30; i++) begin
      run_op("rand", {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom), int'($urandom_range(0, 2)), 0, 32'h0, 4'h0);
    end

    // Reset while the 32/8 unit is working on limb 2.
    a_in = 64'h04E88C94; b_in = 64'h0000250B; op = 1'b0; rev = 1'b0; use_cin = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset out_valid", 64'(out_valid_a), 64'(0));
    check("midreset s",         64'(s_a), 64'(0));
    check("midreset nzcv",      64'({n_a, z_a, c_a, v_a}), 64'(0));
    check("midreset in_ready",  64'(in_ready_a), 64'(1));
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid_a || out_valid_b || out_valid_c) seen = 1;
    end
    check("midreset no out_valid", 64'(seen), 64'(0));
    run_op("post reset", 64'h04E88C94, 64'h0000250B, 0, 0, 0, 0, 0, 1, 32'h04E8B19F, 4'b0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
